// File: rtl/neuron_net_ctrl_if.sv
// Byte-stream, config-bank and timestep signals between the pin logic and
// the neuron_net_ctrl sequencer.
interface neuron_net_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
);
   logic              ena;
   logic              cfg_mode;
   logic [7:0]        din;
   logic              din_valid;
   logic              din_ready;
   logic [ADDR_W-1:0] cfg_addr;
   logic [7:0]        cfg_data;
   logic              cfg_we;
   logic              cfg_done;
   logic              step;
   logic [CNT_W-1:0]  step_count;
   logic              busy;

   modport master (
      output ena, cfg_mode, din, din_valid,
      input  din_ready, cfg_addr, cfg_data, cfg_we, cfg_done, step, step_count, busy
   );

   modport slave (
      input  ena, cfg_mode, din, din_valid,
      output din_ready, cfg_addr, cfg_data, cfg_we, cfg_done, step, step_count, busy
   );
endinterface

// File: rtl/neuron_net_ctrl.sv
// Config loader and timestep sequencer for the LIF network core: loads a
// period header plus CFG_WORDS bank bytes, then strobes step every period.
module neuron_net_ctrl #(
   parameter int CFG_WORDS = 20,
   parameter int ADDR_W    = 5,
   parameter int CNT_W     = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   neuron_net_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_LOAD,
      S_RUN
   } state_t;

   state_t            r_state;
   logic [7:0]        r_period;
   logic [8:0]        r_down;
   logic [ADDR_W-1:0] r_idx;
   logic              r_done_pend;
   logic [ADDR_W-1:0] r_cfg_addr;
   logic [7:0]        r_cfg_data;
   logic              r_cfg_we;
   logic              r_cfg_done;
   logic              r_step;
   logic [CNT_W-1:0]  r_step_count;
   logic              r_busy;

   logic              w_accept;
   logic              w_last;
   logic [8:0]        w_reload;

   assign bus.din_ready = bus.ena & ((r_state == S_HDR) | (r_state == S_LOAD));
   assign w_accept      = bus.din_valid & bus.din_ready;
   assign w_last        = (r_idx == ADDR_W'(CFG_WORDS - 1));
   assign w_reload      = (r_period == 8'd0) ? 9'd256 : {1'b0, r_period};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_period     <= 8'd1;
         r_down       <= '0;
         r_idx        <= '0;
         r_done_pend  <= 1'b0;
         r_cfg_addr   <= '0;
         r_cfg_data   <= '0;
         r_cfg_we     <= 1'b0;
         r_cfg_done   <= 1'b0;
         r_step       <= 1'b0;
         r_step_count <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_cfg_we <= 1'b0;
         r_step   <= 1'b0;
         if (bus.ena) begin
            case (r_state)
               // cfg_done is raised one IDLE cycle after the final write
               S_IDLE: begin
                  if (bus.cfg_mode) begin
                     r_state     <= S_HDR;
                     r_busy      <= 1'b1;
                     r_cfg_done  <= 1'b0;
                     r_done_pend <= 1'b0;
                  end else if (r_done_pend) begin
                     r_cfg_done  <= 1'b1;
                     r_done_pend <= 1'b0;
                  end else if (r_cfg_done) begin
                     r_state      <= S_RUN;
                     r_down       <= w_reload;
                     r_step_count <= '0;
                  end
               end
               S_HDR: begin
                  if (!bus.cfg_mode) begin
                     r_state    <= S_IDLE;
                     r_busy     <= 1'b0;
                     r_cfg_done <= 1'b0;
                  end else if (w_accept) begin
                     r_period <= bus.din;
                     r_idx    <= '0;
                     r_state  <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  if (!bus.cfg_mode) begin
                     r_state    <= S_IDLE;
                     r_busy     <= 1'b0;
                     r_cfg_done <= 1'b0;
                  end else if (w_accept) begin
                     r_cfg_we   <= 1'b1;
                     r_cfg_addr <= r_idx;
                     r_cfg_data <= bus.din;
                     r_idx      <= r_idx + ADDR_W'(1);
                     if (w_last) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_done_pend <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  if (bus.cfg_mode) begin
                     r_state    <= S_HDR;
                     r_busy     <= 1'b1;
                     r_cfg_done <= 1'b0;
                  end else if (r_down == 9'd1) begin
                     r_step       <= 1'b1;
                     r_down       <= w_reload;
                     r_step_count <= r_step_count + CNT_W'(1);
                  end else begin
                     r_down <= r_down - 9'd1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.cfg_addr   = r_cfg_addr;
   assign bus.cfg_data   = r_cfg_data;
   assign bus.cfg_we     = r_cfg_we;
   assign bus.cfg_done   = r_cfg_done;
   assign bus.step       = r_step;
   assign bus.step_count = r_step_count;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_neuron_net_ctrl.sv
// Scenario bench for neuron_net_ctrl: config writes go through a scoreboard
// queue, step timing is checked against an enabled-cycle model.
module tb_neuron_net_ctrl;

   typedef struct packed {
      logic [4:0] a;
      logic [7:0] d;
   } wr_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   wr_t  exp_q[$];

   neuron_net_ctrl_if #(.ADDR_W(5), .CNT_W(16)) ifc ();

   neuron_net_ctrl #(.CFG_WORDS(20), .ADDR_W(5), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; ifc.ena = 1'b1; ifc.cfg_mode = 1'b0; ifc.din = 8'h00; ifc.din_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (ifc.din_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ifc.din_ready); end
      total++; if (ifc.cfg_addr !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", ifc.cfg_addr); end
      total++; if (ifc.cfg_data !== 8'd0) begin bad++; $display("FAIL rst_data got=%h exp=00", ifc.cfg_data); end
      total++; if (ifc.cfg_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", ifc.cfg_we); end
      total++; if (ifc.cfg_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", ifc.cfg_done); end
      total++; if (ifc.step !== 1'b0) begin bad++; $display("FAIL rst_step got=%b exp=0", ifc.step); end
      total++; if (ifc.step_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", ifc.step_count); end
      total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", ifc.busy); end
      rst_n = 1'b1;
   endtask

   // nbytes < 20 aborts by dropping cfg_mode while byte nbytes is presented
   task automatic load_cfg(input logic [7:0] hdr, input logic [7:0] base,
                           input int nbytes, input int fz_at);
      wr_t w;
      logic [7:0] b;
      ifc.cfg_mode = 1'b1; ifc.din_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL hdr_busy got=%b exp=1", ifc.busy); end
      total++; if (ifc.cfg_done !== 1'b0) begin bad++; $display("FAIL hdr_done got=%b exp=0", ifc.cfg_done); end
      total++; if (ifc.din_ready !== 1'b1) begin bad++; $display("FAIL hdr_ready got=%b exp=1", ifc.din_ready); end
      ifc.din = hdr; ifc.din_valid = 1'b1;
      @(posedge clk); #1;
      total++; if (ifc.cfg_we !== 1'b0) begin bad++; $display("FAIL hdr_no_we got=%b exp=0", ifc.cfg_we); end
      for (int i = 0; i < nbytes; i++) begin
         b = base + 8'(i);
         ifc.din = b;
         if (i == fz_at) begin
            ifc.ena = 1'b0;
            #0;
            for (int k = 0; k < 10; k++) begin
               total++; if (ifc.din_ready !== 1'b0) begin bad++; $display("FAIL load_fz_ready k=%0d got=%b exp=0", k, ifc.din_ready); end
               @(posedge clk); #1;
               total++; if (ifc.cfg_we !== 1'b0) begin bad++; $display("FAIL load_fz_we k=%0d got=%b exp=0", k, ifc.cfg_we); end
            end
            ifc.ena = 1'b1;
         end
         w.a = 5'(i); w.d = b;
         exp_q.push_back(w);
         @(posedge clk); #1;
         total++; if (ifc.cfg_we !== 1'b1) begin bad++; $display("FAIL load_we i=%0d got=%b exp=1", i, ifc.cfg_we); end
      end
      if (nbytes == 20) begin
         total++; if (ifc.cfg_done !== 1'b0) begin bad++; $display("FAIL done_early got=%b exp=0", ifc.cfg_done); end
         ifc.cfg_mode = 1'b0; ifc.din_valid = 1'b0;
         @(posedge clk); #1;
         total++; if (ifc.cfg_done !== 1'b1) begin bad++; $display("FAIL done_rise got=%b exp=1", ifc.cfg_done); end
         total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL done_busy got=%b exp=0", ifc.busy); end
         total++; if (ifc.cfg_addr !== 5'd19) begin bad++; $display("FAIL addr_hold got=%0d exp=19", ifc.cfg_addr); end
         total++; if (ifc.cfg_data !== base + 8'd19) begin bad++; $display("FAIL data_hold got=%h exp=%h", ifc.cfg_data, base + 8'd19); end
         total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wr_missing got=%0d exp=0", exp_q.size()); end
      end else begin
         ifc.din = base + 8'(nbytes); ifc.din_valid = 1'b1; ifc.cfg_mode = 1'b0;
         @(posedge clk); #1;
         ifc.din_valid = 1'b0;
         for (int k = 0; k < 20; k++) begin
            total++; if (ifc.cfg_we !== 1'b0) begin bad++; $display("FAIL abort_we k=%0d got=%b exp=0", k, ifc.cfg_we); end
            total++; if (ifc.cfg_done !== 1'b0) begin bad++; $display("FAIL abort_done k=%0d got=%b exp=0", k, ifc.cfg_done); end
            total++; if (ifc.busy !== 1'b0 || ifc.step !== 1'b0) begin bad++; $display("FAIL abort_idle k=%0d busy=%b step=%b exp=0,0", k, ifc.busy, ifc.step); end
            @(posedge clk); #1;
         end
         total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_q got=%0d exp=0", exp_q.size()); end
      end
   endtask

   // e counts edges with ena=1 since RUN entry; step fires when e hits a multiple of per
   task automatic run_check(input int per, input int ncyc, input int fz_at, input int fz_len);
      int e;
      bit en;
      logic exp_step;
      logic [15:0] exp_cnt;
      @(posedge clk); #1;
      e = 0;
      total++; if (ifc.step !== 1'b0 || ifc.step_count !== 16'd0) begin bad++; $display("FAIL run_entry step=%b cnt=%0d exp=0,0", ifc.step, ifc.step_count); end
      total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL run_busy got=%b exp=0", ifc.busy); end
      for (int c = 1; c <= ncyc; c++) begin
         en = !(c > fz_at && c <= fz_at + fz_len);
         ifc.ena = en;
         @(posedge clk); #1;
         if (en) e++;
         exp_step = en && (e % per == 0);
         exp_cnt  = 16'(e / per);
         total++; if (ifc.step !== exp_step) begin bad++; $display("FAIL run_step c=%0d got=%b exp=%b", c, ifc.step, exp_step); end
         total++; if (ifc.step_count !== exp_cnt) begin bad++; $display("FAIL run_count c=%0d got=%0d exp=%0d", c, ifc.step_count, exp_cnt); end
      end
      ifc.ena = 1'b1;
   endtask

   task automatic test_load_and_run();
      load_cfg(8'h04, 8'h10, 20, -1);
      run_check(4, 40, -1, 0);
   endtask

   task automatic test_abort();
      load_cfg(8'h04, 8'h40, 7, -1);
   endtask

   task automatic test_period_256();
      load_cfg(8'h00, 8'h80, 20, -1);
      run_check(256, 800, -1, 0);
   endtask

   task automatic test_ena_freeze();
      load_cfg(8'h06, 8'h20, 20, 5);
      run_check(6, 60, 9, 10);
   endtask

   task automatic test_preempt();
      load_cfg(8'h03, 8'h50, 20, -1);
      run_check(3, 5, -1, 0);
      ifc.cfg_mode = 1'b1;
      @(posedge clk); #1;
      total++; if (ifc.step !== 1'b0) begin bad++; $display("FAIL pre_step got=%b exp=0", ifc.step); end
      total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL pre_busy got=%b exp=1", ifc.busy); end
      total++; if (ifc.cfg_done !== 1'b0) begin bad++; $display("FAIL pre_done got=%b exp=0", ifc.cfg_done); end
      total++; if (ifc.step_count !== 16'd1) begin bad++; $display("FAIL pre_count got=%0d exp=1", ifc.step_count); end
      ifc.cfg_mode = 1'b0;
      @(posedge clk); #1;
      total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL pre_abort got=%b exp=0", ifc.busy); end
   endtask

   task automatic test_wrap();
      load_cfg(8'h01, 8'h70, 20, -1);
      run_check(1, 65540, -1, 0);
   endtask

   task automatic test_reset_mid_run();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++; if (ifc.step !== 1'b0 || ifc.step_count !== 16'd0) begin bad++; $display("FAIL mrst_step step=%b cnt=%0d exp=0,0", ifc.step, ifc.step_count); end
      total++; if (ifc.cfg_addr !== 5'd0 || ifc.cfg_data !== 8'd0) begin bad++; $display("FAIL mrst_bank addr=%0d data=%h exp=0,00", ifc.cfg_addr, ifc.cfg_data); end
      total++; if (ifc.cfg_done !== 1'b0 || ifc.busy !== 1'b0) begin bad++; $display("FAIL mrst_flags done=%b busy=%b exp=0,0", ifc.cfg_done, ifc.busy); end
      total++; if (ifc.din_ready !== 1'b0) begin bad++; $display("FAIL mrst_ready got=%b exp=0", ifc.din_ready); end
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         total++; if (ifc.step !== 1'b0 || ifc.busy !== 1'b0 || ifc.cfg_done !== 1'b0) begin bad++; $display("FAIL mrst_idle k=%0d step=%b busy=%b done=%b exp=0,0,0", k, ifc.step, ifc.busy, ifc.cfg_done); end
      end
   endtask

   task automatic test_back_to_back();
      load_cfg(8'h02, 8'h60, 20, -1);
      run_check(2, 10, -1, 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      fork
         forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ifc.cfg_we === 1'b1) begin
               wr_t w;
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL wr_unexpected addr=%0d data=%h exp=none", ifc.cfg_addr, ifc.cfg_data);
               end else begin
                  w = exp_q.pop_front();
                  if (ifc.cfg_addr !== w.a || ifc.cfg_data !== w.d) begin
                     bad++;
                     $display("FAIL wr_pair addr=%0d data=%h exp=%0d,%h", ifc.cfg_addr, ifc.cfg_data, w.a, w.d);
                  end
               end
            end
         end
      join_none
      test_reset();
      test_load_and_run();
      test_abort();
      test_period_256();
      test_ena_freeze();
      test_preempt();
      test_wrap();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/neuron_net_ctrl.md
# neuron_net_ctrl

Sequencing and configuration controller for the `tt_um_neuron_net` LIF network. Sits between the TinyTapeout pins and the network core.
- In config mode it accepts a byte stream: one header byte (timestep period), then `CFG_WORDS` synaptic-weight/threshold bytes, which it writes into the core's config bank.
- In run mode it issues a one-cycle `step` strobe every programmed period and counts timesteps.

## Interface
Parameters:
- `CFG_WORDS`, 20: number of config bytes after the header (4×4 weights + 4 thresholds).
- `ADDR_W`, 5: width of `cfg_addr`; `2**ADDR_W >= CFG_WORDS`.
- `CNT_W`, 16: width of the timestep counter.

Ports:
- `clk`, in, 1: system clock, single clock domain.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `ena`, in, 1: design enable. When 0, all state holds, `din_ready`=0, no `cfg_we`/`step` pulses.
- `cfg_mode`, in, 1: 1 = configure, 0 = run.
- `din`, in, 8: config byte.
- `din_valid`, in, 1: `din` valid this cycle.
- `din_ready`, out, 1: controller accepts `din` this cycle.
- `cfg_addr`, out, ADDR_W: config-bank write address.
- `cfg_data`, out, 8: config-bank write data.
- `cfg_we`, out, 1: one-cycle write strobe.
- `cfg_done`, out, 1: a complete config load has finished and not been invalidated.
- `step`, out, 1: one-cycle timestep strobe to the network core.
- `step_count`, out, CNT_W: timesteps issued since entering RUN.
- `busy`, out, 1: state is HDR or LOAD.

## Operation
- Reset values: state IDLE; `din_ready`=0, `cfg_addr`=0, `cfg_data`=0, `cfg_we`=0, `cfg_done`=0, `step`=0, `step_count`=0, `busy`=0; period register=1; down-counter=0.
- A byte is accepted when `din_valid & din_ready` is true.
- `din_ready` = `ena` & (state ∈ {HDR, LOAD}); it is combinational from state.
- State transitions (all gated by `ena`=1):
  - IDLE: `cfg_mode`=1 → HDR and clear `cfg_done`. Otherwise, if `cfg_mode`=0 and `cfg_done`=1 → RUN. Otherwise stay.
  - HDR: accept one byte into the period register P. P=0 is stored as-is and means 256 cycles. Then → LOAD with the write index cleared to 0. The header byte produces no `cfg_we`.
  - LOAD: each accepted byte produces, on the next cycle, `cfg_we`=1 with `cfg_addr`=index and `cfg_data`=byte; index then increments. After the byte at index `CFG_WORDS-1` is accepted: set `cfg_done`=1 and go → IDLE.
  - Abort: if `cfg_mode`=0 is sampled in HDR or LOAD → IDLE with `cfg_done`=0. A byte accepted in that same cycle is dropped, and no write is issued for it.
  - RUN: on entry, down-counter = P (0 → 256) and `step_count`=0. Each cycle the counter decrements. When it reaches 1, `step` pulses on the next cycle and the counter reloads P. `step_count` increments with each pulse and wraps modulo 2^CNT_W.
  - RUN: `cfg_mode`=1 → HDR and clear `cfg_done`. `step_count` holds its value until the next RUN entry.
- `cfg_addr`/`cfg_data` hold their last values when `cfg_we`=0.
- `busy` is registered alongside the state.

## Timing
- Latency from byte acceptance to `cfg_we` is exactly 1 cycle.
- Back-to-back bytes are accepted at 1 per cycle, so `cfg_we` can be high on consecutive cycles.
- `cfg_done` rises in the cycle after the last `cfg_we`.
- IDLE→RUN takes 1 cycle after `cfg_mode`=0 with `cfg_done`=1.
- The first `step` comes exactly P cycles after the first cycle in RUN; step period is P cycles (256 for P=0). With P=1, `step` is high every cycle.
- `ena`=0 freezes the state, index, down-counter and `step_count`. Any `cfg_we`/`step` that would fire is suppressed, not deferred. Counting resumes where it stopped when `ena` returns to 1.
- Synchronous reset mid-operation returns everything to the reset values on the next edge. `cfg_done` is cleared, so RUN cannot resume until a full reload.
- Simultaneous `cfg_mode`=1 and a step expiry in RUN: the mode change wins and no `step` is issued.

## Test plan
- Reset, then `cfg_mode`=1, header 0x04, then 20 bytes 0x10..0x23 back-to-back → 20 consecutive `cfg_we` pulses, addr 0..19 paired with data 0x10..0x23. `cfg_done`=1 one cycle after the last write.
- After that load, `cfg_mode`=0 → `step` pulses at cycles 4, 8, 12… after RUN entry, and `step_count` reads 3 after the third pulse.
- Header 0x00 → steps 256 cycles apart. Header 0x01 → `step` high every cycle, and `step_count` wraps 0xFFFF→0x0000.
- Drop `cfg_mode` after 7 config bytes → no further `cfg_we`, `cfg_done`=0, controller stays IDLE (no `step`) with `cfg_mode`=0.
- Hold `ena`=0 for 10 cycles during LOAD and during RUN → `din_ready`=0, no pulses. The step phase resumes exactly where it stopped.
- Assert `rst_n`=0 for one cycle mid-RUN → all outputs return to reset values, `step` stops, and a new full load is required.
